// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: two cache ports and one memory port, shared by the arbiter and its environment.
interface mem_arbiter_if;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1;
    logic [3:0]  beat_cnt;
    logic [31:0] rdata;
    logic        rvalid0, rvalid1, done0, done1;
    logic        mem_rd, mem_wr, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_ack,
        output gnt0, gnt1, beat_cnt, rdata, rvalid0, rvalid1, done0, done1,
               mem_rd, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_ack,
        input  gnt0, gnt1, beat_cnt, rdata, rvalid0, rvalid1, done0, done1,
               mem_rd, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin burst arbiter giving two cache ports turns on a single word-wide memory.
module mem_arbiter #(
    parameter int BEATS = 16
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2} state_t;

    state_t      r_state;
    logic [3:0]  r_beat;
    logic [31:0] r_base;
    logic        r_last, r_owner, r_we, r_gnt0, r_gnt1, r_done0, r_done1;
    logic        w_win, w_xfer, w_rv;
    logic [31:0] w_addr;

    // r_last names the port granted last, so a tie goes to the other one
    assign w_win  = bus.req1 & (~bus.req0 | ~r_last);
    assign w_addr = w_win ? bus.addr1 : bus.addr0;
    assign w_xfer = r_state == XFER;
    assign w_rv   = w_xfer & ~r_we & bus.mem_ack;

    assign bus.gnt0      = r_gnt0;
    assign bus.gnt1      = r_gnt1;
    assign bus.done0     = r_done0;
    assign bus.done1     = r_done1;
    assign bus.beat_cnt  = r_beat;
    assign bus.mem_rd    = w_xfer & ~r_we;
    assign bus.mem_wr    = w_xfer & r_we;
    assign bus.mem_addr  = w_xfer ? r_base | {26'd0, r_beat, 2'b00} : 32'd0;
    assign bus.mem_wdata = w_xfer ? (r_owner ? bus.wdata1 : bus.wdata0) : 32'd0;
    assign bus.rvalid0   = w_rv & ~r_owner;
    assign bus.rvalid1   = w_rv & r_owner;
    assign bus.rdata     = w_rv ? bus.mem_rdata : 32'd0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_beat  <= 4'd0;
            r_base  <= 32'd0;
            r_last  <= 1'b0;
            r_owner <= 1'b0;
            r_we    <= 1'b0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.req0 | bus.req1) begin
                    r_state <= XFER;
                    r_owner <= w_win;
                    r_we    <= w_win ? bus.we1 : bus.we0;
                    r_base  <= w_addr & 32'hFFFF_FFC0;
                    r_beat  <= 4'd0;
                    r_gnt0  <= ~w_win;
                    r_gnt1  <= w_win;
                end
                XFER: if (bus.mem_ack) begin
                    r_beat <= r_beat + 4'd1;
                    if (r_beat == 4'(BEATS - 1)) begin
                        r_state <= DONE;
                        r_beat  <= 4'd0;
                        r_done0 <= ~r_owner;
                        r_done1 <= r_owner;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_last  <= r_owner;
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                    r_done0 <= 1'b0;
                    r_done1 <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                    r_done0 <= 1'b0;
                    r_done1 <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bursts on both ports; every memory word is checked through a scoreboard queue.
module tb_mem_arbiter;
    typedef struct {
        logic        p;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    int    n_tests = 0;
    int    n_fail  = 0;
    exp_t  sbq[$];

    mem_arbiter_if bus();
    mem_arbiter #(.BEATS(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {20'd0, bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.done0,
                            bus.done1, bus.mem_rd, bus.mem_wr, bus.beat_cnt}, 32'd0);
        chk({tag, "_addr"}, bus.mem_addr, 32'd0);
        chk({tag, "_wdata"}, bus.mem_wdata, 32'd0);
        chk({tag, "_rdata"}, bus.rdata, 32'd0);
    endtask

    // every read word or accepted write word must match the oldest outstanding entry
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst && (bus.rvalid0 || bus.rvalid1 || (bus.mem_wr && bus.mem_ack))) begin
            chk("sb_depth", 32'(sbq.size()), 32'd1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("sb_port", {31'd0, bus.rvalid1 | (bus.mem_wr & bus.gnt1)}, {31'd0, e.p});
                chk("sb_dir", {31'd0, bus.mem_wr}, {31'd0, e.wr});
                chk("sb_addr", bus.mem_addr, e.a);
                chk("sb_data", e.wr ? bus.mem_wdata : bus.rdata, e.d);
            end
        end
    end

    task automatic set_req(input bit p, input bit v);
        if (p) bus.req1 = v;
        else bus.req0 = v;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.mem_ack = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;
    endtask

    task automatic idle_acks();
        repeat (3) begin
            bus.mem_ack = 1'b1;
            bus.mem_rdata = $urandom | 32'h1;
            @(negedge clk);
            chk_zero("idle_ack");
            @(posedge clk);
            #1;
        end
        bus.mem_ack = 1'b0;
    endtask

    // one burst by port p; ack after gap idle cycles; req dropped in the ack of beat drop_at;
    // rst pulled low at the start of beat rst_at (aborting the burst)
    task automatic run_burst(input bit p, input bit we, input logic [31:0] a,
                             input int gap, input int drop_at, input int rst_at);
        logic [31:0] base;
        logic [31:0] ea;
        logic [31:0] wd;
        logic        ack;
        exp_t        e;
        base = a & 32'hFFFF_FFC0;
        if (p) begin
            bus.we1 = we;
            bus.addr1 = a;
        end else begin
            bus.we0 = we;
            bus.addr0 = a;
        end
        set_req(p, 1'b1);
        @(posedge clk);
        #1;
        for (int b = 0; b < 16; b++) begin
            ea = base | 32'(b * 4);
            wd = $urandom;
            if (p) bus.wdata1 = wd;
            else bus.wdata0 = wd;
            for (int w = 0; w <= gap; w++) begin
                if (b == rst_at) begin
                    bus.mem_ack = 1'b0;
                    rst = 1'b0;
                    bus.req0 = 1'b0;
                    bus.req1 = 1'b0;
                    @(posedge clk);
                    #1;
                    rst = 1'b1;
                    @(negedge clk);
                    chk_zero("abort");
                    @(posedge clk);
                    #1;
                    @(negedge clk);
                    chk_zero("abort_idle");
                    return;
                end
                ack = (w == gap);
                bus.mem_ack = ack;
                bus.mem_rdata = $urandom;
                if (ack) begin
                    e.p = p;
                    e.wr = we;
                    e.a = ea;
                    e.d = we ? wd : bus.mem_rdata;
                    sbq.push_back(e);
                    if (b == drop_at) set_req(p, 1'b0);
                end
                @(negedge clk);
                chk("gnt", {30'd0, bus.gnt1, bus.gnt0}, p ? 32'd2 : 32'd1);
                chk("strobes", {30'd0, bus.mem_rd, bus.mem_wr}, we ? 32'd1 : 32'd2);
                chk("mem_addr", bus.mem_addr, ea);
                chk("beat_cnt", {28'd0, bus.beat_cnt}, 32'(b));
                chk("done_early", {30'd0, bus.done1, bus.done0}, 32'd0);
                chk("rvalid", {30'd0, bus.rvalid1, bus.rvalid0},
                    (!we && ack) ? (p ? 32'd2 : 32'd1) : 32'd0);
                if (we) chk("mem_wdata", bus.mem_wdata, wd);
                @(posedge clk);
                #1;
            end
        end
        bus.mem_ack = 1'b0;
        set_req(p, 1'b0);
        @(negedge clk);
        chk("done", {30'd0, bus.done1, bus.done0}, p ? 32'd2 : 32'd1);
        chk("done_gnt", {30'd0, bus.gnt1, bus.gnt0}, p ? 32'd2 : 32'd1);
        chk("done_strobes", {30'd0, bus.mem_rd, bus.mem_wr}, 32'd0);
        chk("done_addr", bus.mem_addr, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_zero("post_idle");
    endtask

    initial begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.we0 = 1'b0;
        bus.we1 = 1'b0;
        bus.addr0 = 32'd0;
        bus.addr1 = 32'd0;
        bus.wdata0 = 32'hA5A5_0000;
        bus.wdata1 = 32'h5A5A_0000;
        bus.mem_rdata = 32'd0;
        bus.mem_ack = 1'b0;
        do_reset();
        idle_acks();
        run_burst(1'b0, 1'b0, 32'h0000_1234, 0, 99, -1);
        do_reset();
        // tie after reset: port 1 first, then the waiting port 0, then port 1 wins the next tie
        bus.req0 = 1'b1;
        run_burst(1'b1, 1'b0, 32'h0000_0080, 0, 99, -1);
        run_burst(1'b0, 1'b0, 32'h0000_2000, 0, 99, -1);
        bus.req0 = 1'b1;
        run_burst(1'b1, 1'b1, 32'h0000_00C0, 0, 99, -1);
        bus.req0 = 1'b0;
        run_burst(1'b1, 1'b1, 32'h0000_0040, 2, 99, -1);
        run_burst(1'b0, 1'b0, 32'h0000_3FFF, 1, 3, -1);
        run_burst(1'b0, 1'b0, 32'h0000_4000, 0, 99, 7);
        run_burst(1'b1, 1'b0, 32'h0000_5040, 0, 99, -1);
        idle_acks();
        chk("sb_left", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
